// File: rtl/axil_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : axil_reg_responder
// Brief    : AXI4-Lite slave exposing NUM_REGS byte-writable 32-bit registers.
// Revision : 1.0 - initial release
// ============================================================================
module axil_reg_responder #(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS           = 8
) (
    input  logic                                         ACLK,
    input  logic                                         ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_AWADDR,
    input  logic                                         S_AXI_AWVALID,
    output logic                                         S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]              S_AXI_WSTRB,
    input  logic                                         S_AXI_WVALID,
    output logic                                         S_AXI_WREADY,
    output logic [1:0]                                   S_AXI_BRESP,
    output logic                                         S_AXI_BVALID,
    input  logic                                         S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                S_AXI_ARADDR,
    input  logic                                         S_AXI_ARVALID,
    output logic                                         S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                S_AXI_RDATA,
    output logic [1:0]                                   S_AXI_RRESP,
    output logic                                         S_AXI_RVALID,
    input  logic                                         S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0]       REG_OUT,
    output logic                                         WR_PULSE,
    output logic [$clog2(NUM_REGS > 1 ? NUM_REGS : 2)-1:0] WR_INDEX
);

    localparam int              c_aiw      = C_S_AXI_ADDR_WIDTH - 2;
    localparam int              c_idx_w    = $clog2(NUM_REGS > 1 ? NUM_REGS : 2);
    localparam int              c_dw       = C_S_AXI_DATA_WIDTH;
    localparam int              c_sw       = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [c_aiw:0]  c_num_regs = NUM_REGS[c_aiw:0];
    localparam logic [1:0]      c_okay     = 2'b00;
    localparam logic [1:0]      c_slverr   = 2'b10;

    logic [c_dw-1:0]    r_regs [NUM_REGS];
    logic               r_ready_en;
    logic               r_aw_full;
    logic [c_aiw-1:0]   r_aw_idx;
    logic               r_w_full;
    logic [c_dw-1:0]    r_wdata;
    logic [c_sw-1:0]    r_wstrb;
    logic               r_bvalid;
    logic [1:0]         r_bresp;
    logic               r_wr_pulse;
    logic [c_idx_w-1:0] r_wr_index;
    logic               r_rvalid;
    logic [c_dw-1:0]    r_rdata;
    logic [1:0]         r_rresp;

    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_ar_hs;
    logic               w_exec;
    logic               w_aw_in_range;
    logic [c_aiw-1:0]   w_ar_idx;
    logic               w_ar_in_range;
    logic [c_idx_w-1:0] w_aw_sel;
    logic [c_idx_w-1:0] w_ar_sel;
    logic               w_unused_addr_lsbs;

    // Ready flags derive only from registered state; r_ready_en holds them low
    // through reset and the first cycle after release.
    assign S_AXI_AWREADY = r_ready_en & ~r_aw_full & ~r_bvalid;
    assign S_AXI_WREADY  = r_ready_en & ~r_w_full & ~r_bvalid;
    assign S_AXI_ARREADY = r_ready_en & ~r_rvalid;

    assign w_aw_hs       = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_w_hs        = S_AXI_WVALID & S_AXI_WREADY;
    assign w_ar_hs       = S_AXI_ARVALID & S_AXI_ARREADY;
    assign w_exec        = r_aw_full & r_w_full;

    assign w_aw_in_range = {1'b0, r_aw_idx} < c_num_regs;
    assign w_aw_sel      = r_aw_idx[c_idx_w-1:0];
    assign w_ar_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign w_ar_in_range = {1'b0, w_ar_idx} < c_num_regs;
    assign w_ar_sel      = w_ar_idx[c_idx_w-1:0];

    assign w_unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_ready_en <= 1'b0;
            r_aw_full  <= 1'b0;
            r_aw_idx   <= '0;
            r_w_full   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= c_okay;
            r_wr_pulse <= 1'b0;
            r_wr_index <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            r_ready_en <= 1'b1;
            r_wr_pulse <= 1'b0;
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_wdata  <= S_AXI_WDATA;
                r_wstrb  <= S_AXI_WSTRB;
            end
            // Latches drop at execute; BVALID alone then blocks new captures.
            if (w_exec) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_aw_in_range ? c_okay : c_slverr;
                if (w_aw_in_range) begin
                    r_wr_pulse <= 1'b1;
                    r_wr_index <= w_aw_sel;
                    for (int b = 0; b < c_sw; b++) begin
                        if (r_wstrb[b]) begin
                            r_regs[w_aw_sel][8*b +: 8] <= r_wdata[8*b +: 8];
                        end
                    end
                end
            end
            if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Nonblocking capture returns the pre-write value if a write executes on
    // the same edge as the AR handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= c_okay;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_ar_in_range ? r_regs[w_ar_sel] : '0;
            r_rresp  <= w_ar_in_range ? c_okay : c_slverr;
        end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
            assign REG_OUT[c_dw*k +: c_dw] = r_regs[k];
        end
    endgenerate

    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_BRESP  = r_bresp;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_RRESP  = r_rresp;
    assign WR_PULSE     = r_wr_pulse;
    assign WR_INDEX     = r_wr_index;

endmodule

`default_nettype wire

// File: tb/tb_axil_reg_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_reg_responder
// Brief    : Vector table, corner sequences and random traffic vs. a register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_reg_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [5:0]   araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [255:0] reg_out;
    logic         wr_pulse;
    logic [2:0]   wr_index;

    axil_reg_responder #(
        .C_S_AXI_ADDR_WIDTH(6),
        .C_S_AXI_DATA_WIDTH(32),
        .NUM_REGS          (8)
    ) dut (
        .ACLK         (clk),
        .ARESET       (rst),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .REG_OUT      (reg_out),
        .WR_PULSE     (wr_pulse),
        .WR_INDEX     (wr_index)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_brise  = 0;
    int n_pulse  = 0;
    logic bvalid_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bvalid && !bvalid_q) n_brise <= n_brise + 1;
        if (wr_pulse) n_pulse <= n_pulse + 1;
        bvalid_q <= bvalid;
    end

    // Reference model: eight registers, index = addr[5:2], out of range >= 8.
    logic [31:0] model [8];

    function automatic logic [1:0] model_resp(input logic [5:0] a);
        return (a[5:2] < 4'd8) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [5:0] a);
        return (a[5:2] < 4'd8) ? model[a[4:2]] : 32'h0;
    endfunction

    function automatic logic [255:0] model_flat();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = model[k];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_flat(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_bvalid(input string name);
        int k = 0;
        while (!bvalid && k < 64) begin @(negedge clk); k++; end
        chk(name, 32'(k >= 64), 32'd0);
    endtask

    task automatic wait_rvalid(input string name);
        int k = 0;
        while (!rvalid && k < 64) begin @(negedge clk); k++; end
        chk(name, 32'(k >= 64), 32'd0);
    endtask

    // Full write with independent AW/W start delays and a BREADY stall.
    task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input logic [1:0] exp_resp);
        int  aw_cyc = 0, w_cyc = 0, hs, brise0, pulse0;
        bit  to_aw = 0, to_w = 0;
        logic exp_pulse;
        brise0    = n_brise;
        pulse0    = n_pulse;
        exp_pulse = (exp_resp == 2'b00);
        fork
            begin
                int k = 0;
                repeat (aw_dly) @(negedge clk);
                awaddr = a; awvalid = 1'b1;
                while (!awready && k < 64) begin @(negedge clk); k++; end
                to_aw  = (k >= 64);
                aw_cyc = cyc;
                @(negedge clk); awvalid = 1'b0;
            end
            begin
                int k = 0;
                repeat (w_dly) @(negedge clk);
                wdata = d; wstrb = s; wvalid = 1'b1;
                while (!wready && k < 64) begin @(negedge clk); k++; end
                to_w  = (k >= 64);
                w_cyc = cyc;
                @(negedge clk); wvalid = 1'b0;
            end
        join
        chk("aw_handshake_timeout", 32'(to_aw), 32'd0);
        chk("w_handshake_timeout", 32'(to_w), 32'd0);
        hs = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
        wait_bvalid("bvalid_timeout");
        chk("write_latency", 32'(cyc - hs), 32'd2);
        chk("bresp", 32'(bresp), 32'(exp_resp));
        chk("wr_pulse_at_bvalid", 32'(wr_pulse), 32'(exp_pulse));
        if (exp_pulse) chk("wr_index", 32'(wr_index), 32'(a[4:2]));
        if (a[5:2] < 4'd8)
            for (int b = 0; b < 4; b++) if (s[b]) model[a[4:2]][8*b +: 8] = d[8*b +: 8];
        chk_flat("reg_out_after_write", reg_out, model_flat());
        for (int i = 0; i < b_dly; i++) begin
            chk("bvalid_held", 32'({bvalid, bresp, awready, wready}), 32'({1'b1, exp_resp, 2'b00}));
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        #1;
        chk("single_bvalid", 32'(n_brise - brise0), 32'd1);
        chk("pulse_count", 32'(n_pulse - pulse0), 32'(exp_pulse));
    endtask

    task automatic do_read(input logic [5:0] a, input int ar_dly, input int r_dly,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int k = 0, hs;
        repeat (ar_dly) @(negedge clk);
        araddr = a; arvalid = 1'b1;
        while (!arready && k < 64) begin @(negedge clk); k++; end
        chk("ar_handshake_timeout", 32'(k >= 64), 32'd0);
        hs = cyc;
        @(negedge clk); arvalid = 1'b0;
        wait_rvalid("rvalid_timeout");
        chk("read_latency", 32'(cyc - hs), 32'd1);
        chk("rdata", rdata, exp_data);
        chk("rresp", 32'(rresp), 32'(exp_resp));
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            chk("rvalid_held", 32'(rvalid), 32'd1);
            chk("rdata_held", rdata, exp_data);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("rvalid_clear", 32'(rvalid), 32'd0);
    endtask

    typedef struct {
        bit          is_wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 32'h0;

        tbl[0]  = '{1, 6'h04, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 32'h0};
        tbl[1]  = '{0, 6'h04, 32'h0,        4'h0, 0, 0, 2'b00, 32'hDEADBEEF};
        tbl[2]  = '{1, 6'h04, 32'h0000AA00, 4'h2, 3, 0, 2'b00, 32'h0};
        tbl[3]  = '{0, 6'h04, 32'h0,        4'h0, 0, 0, 2'b00, 32'hDEADAAEF};
        tbl[4]  = '{1, 6'h3C, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b10, 32'h0};
        tbl[5]  = '{0, 6'h3C, 32'h0,        4'h0, 0, 0, 2'b10, 32'h0};
        tbl[6]  = '{1, 6'h1F, 32'hA5A5A5A5, 4'h9, 0, 2, 2'b00, 32'h0};
        tbl[7]  = '{0, 6'h1C, 32'h0,        4'h0, 0, 0, 2'b00, 32'hA50000A5};
        tbl[8]  = '{0, 6'h20, 32'h0,        4'h0, 0, 0, 2'b10, 32'h0};
        tbl[9]  = '{1, 6'h00, 32'h11223344, 4'h0, 1, 0, 2'b00, 32'h0};
        tbl[10] = '{0, 6'h02, 32'h0,        4'h0, 0, 0, 2'b00, 32'h0};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_readys", 32'({awready, wready, arready}), 32'd0);
        chk("reset_valids", 32'({bvalid, rvalid, wr_pulse}), 32'd0);
        chk("reset_resp_rdata", rdata | 32'({bresp, rresp}), 32'd0);
        chk_flat("reset_reg_out", reg_out, 256'd0);
        rst = 1'b0;
        chk("ready_low_at_release", 32'({awready, wready, arready}), 32'd0);
        @(negedge clk);
        chk("ready_after_release", 32'({awready, wready, arready}), 32'd7);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].is_wr)
                do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].aw_dly, tbl[i].w_dly, 1,
                         tbl[i].exp_resp);
            else
                do_read(tbl[i].addr, 0, 1, tbl[i].exp_rdata, tbl[i].exp_resp);
        end
        chk("reg1_after_strobe", reg_out[63:32], 32'hDEADAAEF);

        // AR lands on the same edge the write to register 2 executes.
        @(negedge clk);
        awaddr = 6'h08; awvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        chk("c34_aw_w_ready", 32'({awready, wready}), 32'd3);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; araddr = 6'h08; arvalid = 1'b1;
        chk("c34_arready", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        chk("c34_rvalid_bvalid", 32'({rvalid, bvalid, wr_pulse}), 32'd7);
        chk("c34_rdata_old", rdata, 32'h0);
        chk("c34_reg2_new", reg_out[95:64], 32'h12345678);
        model[2] = 32'h12345678;
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        do_read(6'h08, 0, 0, 32'h12345678, 2'b00);

        // B held off for 5 cycles while a second AW waits.
        awaddr = 6'h10; awvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        wait_bvalid("c33_bvalid_timeout");
        model[4] = 32'hCAFEF00D;
        awaddr = 6'h14; awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("c33_bvalid_held", 32'({bvalid, bresp}), 32'd4);
            chk("c33_awready_low", 32'(awready), 32'd0);
            @(negedge clk);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("c33_b_done", 32'({bvalid, awready, wready}), 32'd3);
        @(negedge clk);
        awvalid = 1'b0; wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1;
        chk("c33_aw_latched", 32'({awready, wready}), 32'd1);
        @(negedge clk);
        wvalid = 1'b0;
        wait_bvalid("c33_second_bvalid_timeout");
        model[5] = 32'h5A5A5A5A;
        chk("c33_second_bresp", 32'(bresp), 32'd0);
        chk_flat("c33_reg_out", reg_out, model_flat());
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 40; i++) begin
            logic [5:0]  a;
            logic [31:0] d;
            logic [3:0]  s;
            a = 6'($urandom_range(0, 63));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                do_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), model_resp(a));
            else
                do_read(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                        model_rdata(a), model_resp(a));
        end

        // Reset while a read response is stalled.
        @(negedge clk);
        araddr = 6'h04; arvalid = 1'b1;
        k = 0;
        while (!arready && k < 64) begin @(negedge clk); k++; end
        @(negedge clk);
        arvalid = 1'b0;
        wait_rvalid("c35_rvalid_timeout");
        rst = 1'b1;
        @(negedge clk);
        chk("c35_rvalid_cleared", 32'({rvalid, arready}), 32'd0);
        chk_flat("c35_reg_out_zero", reg_out, 256'd0);
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        rst = 1'b0;
        @(negedge clk);
        chk("c35_arready_after_release", 32'({arready, awready}), 32'd3);
        do_read(6'h04, 0, 0, 32'h0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
